// File: rtl/lse_mult_pipe.sv
// rtl/lse_mult_pipe.sv - pipelined, handshaked log-space multiplier with per-lane saturation
// Lane adder plus the STAGES-deep valid/ready pipeline and the saturation event counter.
`timescale 1ns/1ps

module lse_lane_add #(
  parameter int L = 6
) (
  input  logic [L-1:0] i_a,
  input  logic [L-1:0] i_b,
  output logic [L-1:0] o_sum,
  output logic         o_sat
);
  localparam logic [L-1:0] NEG_INF = {1'b1, {(L-1){1'b0}}};
  localparam logic [L-1:0] MAX_POS = {1'b0, {(L-1){1'b1}}};

  logic [L:0] w_s;
  logic       w_hi;
  logic       w_lo;

  assign w_s  = {i_a[L-1], i_a} + {i_b[L-1], i_b};
  // s in [-2^L, -2^(L-1)] clamps to NEG_INF; the exact NEG_INF sum still counts as saturation
  assign w_hi = !w_s[L] && w_s[L-1];
  assign w_lo = w_s[L] && (!w_s[L-1] || (w_s[L-1:0] == NEG_INF));

  always_comb begin
    o_sum = w_s[L-1:0];
    o_sat = 1'b0;
    if (i_a == NEG_INF || i_b == NEG_INF) begin
      o_sum = NEG_INF;
    end else if (w_hi) begin
      o_sum = MAX_POS;
      o_sat = 1'b1;
    end else if (w_lo) begin
      o_sum = NEG_INF;
      o_sat = 1'b1;
    end
  end
endmodule

module lse_mult_pipe #(
  parameter int WIDTH  = 24,
  parameter int LANE_W = 6,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          operand_a,
  input  logic [WIDTH-1:0]          operand_b,
  input  logic [1:0]                pe_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          result,
  output logic [WIDTH/LANE_W-1:0]   sat_flags,
  output logic                      mode_err,
  output logic [CNT_W-1:0]          sat_count,
  input  logic                      cnt_clr
);
  localparam int NL = WIDTH / LANE_W;
  localparam int HW = WIDTH / 2;
  localparam logic [LANE_W-1:0] LANE_NEG_INF = {1'b1, {(LANE_W-1){1'b0}}};

  logic [WIDTH-1:0] w_sum_full;
  logic [WIDTH-1:0] w_sum_half;
  logic [WIDTH-1:0] w_sum_lane;
  logic             w_sat_full;
  logic [1:0]       w_sat_half;
  logic [NL-1:0]    w_sat_lane;
  logic [WIDTH-1:0] w_beat_res;
  logic [NL-1:0]    w_beat_flags;
  logic             w_beat_err;

  lse_lane_add #(.L(WIDTH)) u_full (
    .i_a   (operand_a),
    .i_b   (operand_b),
    .o_sum (w_sum_full),
    .o_sat (w_sat_full)
  );

  for (genvar h = 0; h < 2; h++) begin : g_half
    lse_lane_add #(.L(HW)) u_half (
      .i_a   (operand_a[h*HW +: HW]),
      .i_b   (operand_b[h*HW +: HW]),
      .o_sum (w_sum_half[h*HW +: HW]),
      .o_sat (w_sat_half[h])
    );
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane
    lse_lane_add #(.L(LANE_W)) u_lane (
      .i_a   (operand_a[l*LANE_W +: LANE_W]),
      .i_b   (operand_b[l*LANE_W +: LANE_W]),
      .o_sum (w_sum_lane[l*LANE_W +: LANE_W]),
      .o_sat (w_sat_lane[l])
    );
  end

  always_comb begin
    w_beat_res   = w_sum_full;
    w_beat_flags = '0;
    w_beat_err   = 1'b0;
    case (pe_mode)
      2'b00: w_beat_flags[0] = w_sat_full;
      2'b01: begin
        w_beat_res   = w_sum_lane;
        w_beat_flags = w_sat_lane;
      end
      2'b10: begin
        w_beat_res        = w_sum_half;
        w_beat_flags[1:0] = w_sat_half;
      end
      default: begin
        w_beat_res = {NL{LANE_NEG_INF}};
        w_beat_err = 1'b1;
      end
    endcase
  end

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_res   [STAGES];
  logic [NL-1:0]     r_flags [STAGES];
  logic [STAGES-1:0] r_err;
  logic [STAGES-1:0] w_load;
  logic [CNT_W-1:0]  r_sat_count;
  logic              w_out_fire;

  // A stage may load whenever any stage at or after it has a hole, or the output drains
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign w_load[k] = out_ready || !(&r_valid[STAGES-1:k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_res[k]   <= '0;
        r_flags[k] <= '0;
      end
    end else begin
      for (int k = STAGES-1; k >= 1; k--) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_res[k]   <= r_res[k-1];
            r_flags[k] <= r_flags[k-1];
            r_err[k]   <= r_err[k-1];
          end
        end
      end
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_res[0]   <= w_beat_res;
          r_flags[0] <= w_beat_flags;
          r_err[0]   <= w_beat_err;
        end
      end
    end
  end

  assign w_out_fire = r_valid[STAGES-1] && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (cnt_clr) begin
      r_sat_count <= '0;
    end else if (w_out_fire && (|r_flags[STAGES-1]) && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + CNT_W'(1);
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];
  assign result    = r_res[STAGES-1];
  assign sat_flags = r_flags[STAGES-1];
  assign mode_err  = r_err[STAGES-1];
  assign sat_count = r_sat_count;
endmodule

// File: tb/tb_lse_mult_pipe.sv
// tb/tb_lse_mult_pipe.sv - directed self-checking bench for lse_mult_pipe
// Linear sequence of directed steps with hand-computed expectations.
`timescale 1ns/1ps

module tb_lse_mult_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] operand_a;
  logic [23:0] operand_b;
  logic [1:0]  pe_mode;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] result;
  logic [3:0]  sat_flags;
  logic        mode_err;
  logic [15:0] sat_count;
  logic        cnt_clr;

  int n_cmp = 0;
  int n_err = 0;

  lse_mult_pipe #(.WIDTH(24), .LANE_W(6), .STAGES(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .pe_mode   (pe_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat_flags (sat_flags),
    .mode_err  (mode_err),
    .sat_count (sat_count),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready=1: accepted at edge N, visible after edge N+1
  task automatic send_chk(input string tag, input logic [1:0] m, input logic [23:0] a,
                          input logic [23:0] b, input logic [23:0] er, input logic [3:0] ef,
                          input logic ee);
    pe_mode = m; operand_a = a; operand_b = b; in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat_early"}, out_valid, 0);
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, sat_flags, ef);
    chk({tag, "_err"}, mode_err, ee);
    step();
  endtask

  int sent, got;
  logic stalled_prev;
  logic [23:0] prev_res;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; operand_a = '0; operand_b = '0;
    pe_mode = 2'b00; out_ready = 1'b1; cnt_clr = 1'b0;
    #3 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", sat_flags, 0);
    chk("rst_mode_err", mode_err, 0);
    chk("rst_sat_count", sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    send_chk("m00_add",   2'b00, 24'h100000, 24'h200000, 24'h300000, 4'h0, 1'b0);
    send_chk("m00_max",   2'b00, 24'h7FFFFF, 24'h000001, 24'h7FFFFF, 4'h1, 1'b0);
    send_chk("m00_neginf",2'b00, 24'h800000, 24'h123456, 24'h800000, 4'h0, 1'b0);
    send_chk("m00_low",   2'b00, 24'hC00000, 24'hC00000, 24'h800000, 4'h1, 1'b0);
    send_chk("m01_add",   2'b01, 24'h010203, 24'h040506, 24'h050709, 4'h0, 1'b0);
    send_chk("m01_max",   2'b01, 24'h7DF7DF, 24'h041041, 24'h7DF7DF, 4'hF, 1'b0);
    send_chk("m01_neginf",2'b01, 24'h820820, 24'h7DF7DF, 24'h820820, 4'h0, 1'b0);
    send_chk("m10_mix",   2'b10, 24'h7FF001, 24'h001001, 24'h7FF002, 4'h2, 1'b0);
    send_chk("m11_err",   2'b11, 24'h123456, 24'h654321, 24'h820820, 4'h0, 1'b1);

    // Backpressure: 6 beats, out_ready low for cycles 3-6
    sent = 0; got = 0; stalled_prev = 1'b0; prev_res = '0;
    for (int c = 1; c <= 20; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 6);
      pe_mode   = 2'b00;
      operand_a = 24'(sent);
      operand_b = 24'h000100;
      @(negedge clk);
      chk("bp_in_ready", in_ready, (out_ready || (sent - got) < 2) ? 1 : 0);
      if (stalled_prev) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_result", result, prev_res);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", result, 24'h000100 + 24'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = out_valid && !out_ready;
      prev_res = result;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_got", got, 6);
    chk("bp_drained", out_valid, 0);

    // Counter: clear, then 3 saturating + 1 clean
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("cnt_clr_alone", sat_count, 0);
    send_chk("cnt_s1", 2'b00, 24'h7FFFFF, 24'h000001, 24'h7FFFFF, 4'h1, 1'b0);
    send_chk("cnt_s2", 2'b01, 24'h7DF7DF, 24'h041041, 24'h7DF7DF, 4'hF, 1'b0);
    send_chk("cnt_s3", 2'b10, 24'h7FF001, 24'h001001, 24'h7FF002, 4'h2, 1'b0);
    send_chk("cnt_c1", 2'b00, 24'h100000, 24'h200000, 24'h300000, 4'h0, 1'b0);
    chk("cnt_three", sat_count, 3);

    // cnt_clr in the same cycle as a saturating delivery
    pe_mode = 2'b00; operand_a = 24'h7FFFFF; operand_b = 24'h000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("cnt_clr_pre_valid", out_valid, 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_clr_priority", sat_count, 0);

    // Stream saturating beats to bring the counter near its ceiling
    in_valid = 1'b1;
    repeat (65533) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) step();
    chk("cnt_near_max", sat_count, 16'hFFFD);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) step();
    chk("cnt_saturate", sat_count, 16'hFFFF);

    // Async reset with 2 beats in flight
    out_ready = 1'b0;
    pe_mode = 2'b00; operand_a = 24'h000001; operand_b = 24'h000002; in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    chk("rst2_inflight", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_sat_count", sat_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst2_no_emit", out_valid, 0);
    end
    chk("rst2_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
